// File: rtl/relu_pkg.sv
// rtl/relu_pkg.sv - shared mode encodings and saturation bounds for relu_round_pipe
package relu_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10
  } act_mode_t;

  typedef enum logic {
    RND_HALF_AWAY = 1'b0,
    RND_TRUNC     = 1'b1
  } rnd_mode_t;

  function automatic longint sat_max(input int q);
    return (longint'(1) << (q - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int q);
    return -(longint'(1) << (q - 1));
  endfunction

endpackage

// File: rtl/relu_round_lane.sv
// rtl/relu_round_lane.sv - per-lane activation/rounding (stage 1) and saturation (stage 2) math
module relu_round_lane
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int Q           = 16,
  parameter int IN_FRAC     = 16,
  parameter int OUT_FRAC    = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [1:0]            act_i,
  input  logic                  rnd_i,
  output logic [DATA_WIDTH:0]   r_o,
  input  logic [DATA_WIDTH:0]   r_i,
  output logic [Q-1:0]          y_o,
  output logic                  sat_o
);

  localparam int W     = DATA_WIDTH + 1;
  localparam int SHIFT = IN_FRAC - OUT_FRAC;

  localparam logic signed [W-1:0] HALF    = W'(2 ** (SHIFT - 1));
  localparam logic signed [W-1:0] HALF_M1 = W'(2 ** (SHIFT - 1) - 1);
  localparam logic signed [W-1:0] MAXV    = W'(sat_max(Q));
  localparam logic signed [W-1:0] MINV    = W'(sat_min(Q));

  logic signed [W-1:0] xs, xa, sum, r, ri;
  logic                neg;

  // One guard bit above DATA_WIDTH keeps the rounding bias from wrapping the max input.
  always_comb begin
    xs  = {x_i[DATA_WIDTH-1], x_i};
    neg = x_i[DATA_WIDTH-1];
    xa  = (act_i == ACT_LEAKY && neg) ? (xs >>> LEAKY_SHIFT) : xs;
    if (rnd_i == RND_TRUNC) begin
      sum = xa;
    end else if (neg) begin
      sum = xa + HALF_M1;
    end else begin
      sum = xa + HALF;
    end
    r = sum >>> SHIFT;
    if (act_i == ACT_RELU && neg) begin
      r = '0;
    end
  end

  assign r_o = r;

  always_comb begin
    ri    = r_i;
    y_o   = ri[Q-1:0];
    sat_o = 1'b0;
    if (ri > MAXV) begin
      y_o   = MAXV[Q-1:0];
      sat_o = 1'b1;
    end else if (ri < MINV) begin
      y_o   = MINV[Q-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/relu_round_pipe.sv
// rtl/relu_round_pipe.sv - 2-stage multi-lane activation/round/saturate pipeline with saturation counter
module relu_round_pipe
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int Q           = 16,
  parameter int IN_FRAC     = 16,
  parameter int OUT_FRAC    = 8,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3,
  parameter int SAT_CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                  in_act_mode,
  input  logic                        in_rnd_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*Q-1:0]          out_data,
  output logic [LANES-1:0]            out_sat,
  output logic [SAT_CNT_W-1:0]        sat_count,
  input  logic                        sat_clr
);

  logic                             v1_q, v2_q;
  logic                             adv1, adv2, xfer;
  logic [LANES-1:0][DATA_WIDTH:0]   r_d, r1_q;
  logic [LANES-1:0][Q-1:0]          y_d, out_data_q;
  logic [LANES-1:0]                 sat_d, out_sat_q;
  logic [SAT_CNT_W-1:0]             cnt_q, cnt_d;
  logic [SAT_CNT_W:0]               pop, sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_round_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q          (Q),
      .IN_FRAC    (IN_FRAC),
      .OUT_FRAC   (OUT_FRAC),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .x_i  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .act_i(in_act_mode),
      .rnd_i(in_rnd_mode),
      .r_o  (r_d[i]),
      .r_i  (r1_q[i]),
      .y_o  (y_d[i]),
      .sat_o(sat_d[i])
    );
  end

  assign adv2      = !v2_q || out_ready;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign xfer      = v2_q && out_ready;
  assign out_valid = v2_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = cnt_q;

  // Clear wins over a coincident transfer; the sum saturates instead of wrapping.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + (SAT_CNT_W + 1)'(out_sat_q[i]);
    end
    sum   = {1'b0, cnt_q} + pop;
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = sum[SAT_CNT_W] ? '1 : sum[SAT_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      r1_q       <= '0;
      out_data_q <= '0;
      out_sat_q  <= '0;
      cnt_q      <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          r1_q <= r_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          out_data_q <= y_d;
          out_sat_q  <= sat_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_relu_round_pipe.sv
// tb/tb_relu_round_pipe.sv - randomized self-checking bench for relu_round_pipe against an arithmetic model
module tb_relu_round_pipe;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int Q     = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data = '0;
  logic [1:0]            in_act_mode = 2'b00;
  logic                  in_rnd_mode = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [LANES*Q-1:0]    out_data;
  logic [LANES-1:0]      out_sat;
  logic [15:0]           sat_count;
  logic                  sat_clr = 1'b0;

  always #5 clk = ~clk;

  relu_round_pipe #(
    .DATA_WIDTH(32), .Q(16), .IN_FRAC(16), .OUT_FRAC(8),
    .LANES(4), .LEAKY_SHIFT(3), .SAT_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_act_mode(in_act_mode), .in_rnd_mode(in_rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  typedef struct {
    logic [LANES*Q-1:0] y;
    logic [LANES-1:0]   s;
    int                 acc;
    bit                 seen;
    bit                 has_k;
    int                 k_lane;
    logic [15:0]        k_val;
    logic               k_sat;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  longint      cnt_m = 0;
  bit          lat_exact = 0;
  bit          last_acc = 0;
  bit          saw_full = 0;
  bit          k_pend = 0;
  int          k_lane = 0;
  logic [15:0] k_val = '0;
  logic        k_sat = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint qt;
    qt = a / b;
    if ((a % b != 0) && (a < 0)) qt = qt - 1;
    return qt;
  endfunction

  // Real-valued view: out = round(x / 2^8) in Q8, half-away or floor, then clamp to int16.
  function automatic void model(input logic [LANES*DW-1:0] d, input logic [1:0] act,
                                input logic rnd, output logic [LANES*Q-1:0] y,
                                output logic [LANES-1:0] s);
    longint x, r;
    logic [DW-1:0] w;
    for (int i = 0; i < LANES; i++) begin
      w = d[i*DW +: DW];
      x = longint'($signed(w));
      if (act == 2'b01 && x < 0) begin
        r = 0;
      end else begin
        if (act == 2'b10 && x < 0) x = fdiv(x, 8);
        if (rnd == 1'b0) r = (x >= 0) ? fdiv(x + 128, 256) : -fdiv(-x + 128, 256);
        else             r = fdiv(x, 256);
      end
      s[i] = (r > 32767) || (r < -32768);
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      y[i*Q +: Q] = 16'(r);
    end
  endfunction

  task automatic tick();
    beat_t b;
    #1;
    last_acc = 0;
    if (rst) begin
      exp_q.delete();
      cnt_m  = 0;
      k_pend = 0;
    end else begin
      check("sat_count", sat_count, cnt_m);
      check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (exp_q.size() == 2 && !out_ready) saw_full = 1;
      if (exp_q.size() == 0) begin
        check("idle_out_valid", out_valid, 0);
      end else if (out_valid) begin
        b = exp_q[0];
        check("out_data", out_data, b.y);
        check("out_sat", out_sat, b.s);
        if (!b.seen) begin
          if (lat_exact) check("latency", cyc - b.acc, 2);
          else           check("latency_min", (cyc - b.acc) >= 2, 1);
          if (b.has_k) begin
            check("lane_value", out_data[b.k_lane*Q +: Q], b.k_val);
            check("lane_sat", out_sat[b.k_lane], b.k_sat);
          end
          exp_q[0].seen = 1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          cnt_m = cnt_m + $countones(b.s);
          if (cnt_m > 65535) cnt_m = 65535;
        end
      end
      if (sat_clr) cnt_m = 0;
      if (in_valid && in_ready) begin
        model(in_data, in_act_mode, in_rnd_mode, b.y, b.s);
        b.acc    = cyc;
        b.seen   = 0;
        b.has_k  = k_pend;
        b.k_lane = k_lane;
        b.k_val  = k_val;
        b.k_sat  = k_sat;
        exp_q.push_back(b);
        k_pend   = 0;
        last_acc = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 2047)) - 32'd1024;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_beat();
    for (int i = 0; i < LANES; i++) in_data[i*DW +: DW] = rand_word();
    in_act_mode = 2'($urandom_range(0, 3));
    in_rnd_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic directed(input int lane, input logic [31:0] v, input logic [1:0] a,
                          input logic r, input logic [15:0] kv, input logic ks);
    rand_beat();
    in_data[lane*DW +: DW] = v;
    in_act_mode = a;
    in_rnd_mode = r;
    k_pend = 1; k_lane = lane; k_val = kv; k_sat = ks;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (3) tick();
  endtask

  initial begin
    int sent;
    rst = 1; tick(); tick(); rst = 0;
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sat_count", sat_count, 0);

    lat_exact = 1;
    directed(0, 32'h0000_0180, 2'b00, 1'b0, 16'h0002, 1'b0);
    directed(0, 32'h0000_0180, 2'b00, 1'b1, 16'h0001, 1'b0);
    directed(0, 32'hFFFF_FEC0, 2'b00, 1'b0, 16'hFFFF, 1'b0);
    directed(0, 32'hFFFF_FEC0, 2'b00, 1'b1, 16'hFFFE, 1'b0);
    directed(0, 32'h8000_0000, 2'b00, 1'b0, 16'h8000, 1'b1);
    directed(0, 32'h8000_0000, 2'b01, 1'b0, 16'h0000, 1'b0);
    directed(1, 32'hFFFF_F800, 2'b10, 1'b0, 16'hFFFF, 1'b0);

    rst = 1; tick(); rst = 0;
    in_data = {LANES{32'h7FFF_FFFF}}; in_act_mode = 2'b00; in_rnd_mode = 1'b0;
    k_pend = 1; k_lane = 3; k_val = 16'h7FFF; k_sat = 1'b1;
    in_valid = 1; tick(); tick(); in_valid = 0;
    tick();
    check("sat_count_four", sat_count, 4);
    sat_clr = 1; tick(); sat_clr = 0;
    check("sat_count_clr", sat_count, 0);
    tick();

    lat_exact = 0;
    sent = 0;
    saw_full = 0;
    rand_beat();
    for (int c = 0; c < 200 && (sent < 8 || exp_q.size() > 0); c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid  = (sent < 8);
      tick();
      if (last_acc) begin
        sent++;
        rand_beat();
      end
    end
    check("bp_all_sent", sent, 8);
    check("bp_drained", exp_q.size(), 0);
    check("bp_full_seen", saw_full, 1);

    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      sat_clr   = ($urandom_range(0, 19) == 0);
      if (last_acc || c == 0) rand_beat();
      tick();
    end
    sat_clr = 0;

    out_ready = 0; in_valid = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      out_ready = 1;
      tick();
    end
    out_ready = 0; in_valid = 1; rand_beat();
    tick(); rand_beat(); tick(); tick();
    check("mid_both_full", exp_q.size(), 2);
    rst = 1; in_valid = 0; tick(); rst = 0; out_ready = 1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sat_count", sat_count, 0);
    lat_exact = 1;
    directed(0, 32'h0000_0180, 2'b00, 1'b0, 16'h0002, 1'b0);

    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/relu_round_pipe.md
Name: relu_round_pipe

Overview:
Multi-lane, 2-stage pipelined activation, rounding and saturation unit that replaces the combinational per-accumulator rounding stage.
- Sits between the MAC accumulator bank and the activation buffer write port; uses a valid/ready handshake on both sides.
- Per-beat selectable activation: linear, ReLU or leaky ReLU.
- Per-beat selectable rounding: half-away-from-zero or truncate.
- Per-lane saturation flags, plus a running saturation counter for the quantisation-tuning firmware.

Parameters:
DATA_WIDTH, 32, signed accumulator width per lane
Q, 16, signed output width per lane
IN_FRAC, 16, fractional bits of input
OUT_FRAC, 8, fractional bits of output; SHIFT = IN_FRAC-OUT_FRAC, must be >= 1
LANES, 4, parallel lanes per beat
LEAKY_SHIFT, 3, leaky ReLU negative slope = 2^-LEAKY_SHIFT
SAT_CNT_W, 16, saturation counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_data  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH], two's complement
in_act_mode  in  2  00 linear, 01 ReLU, 10 leaky ReLU, 11 treated as linear
in_rnd_mode  in  1  0 half-away-from-zero, 1 truncate (floor)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*Q  lane i at [i*Q +: Q]
out_sat  out  LANES  per-lane saturation flag, aligned with out_data
sat_count  out  SAT_CNT_W  total saturated lanes since reset/clear
sat_clr  in  1  synchronous clear of sat_count

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sat=0, sat_count=0, internal stage-valid bits=0, in_ready=1.
  - Reset mid-operation discards all in-flight beats.
- Handshakes and pipeline control:
  - Transfer occurs when valid&&ready.
  - v1/v2 are the stage valid bits; v2 drives out_valid.
  - adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready = adv1 (combinational from out_ready, no skid buffer).
  - Latency is 2 cycles; full throughput (1 beat/cycle) when out_ready is held high.
  - Mode bits are captured with the data and travel with the beat.
  - out_data and out_sat must stay stable while out_valid && !out_ready.
- Stage 1 (per lane), all arithmetic signed on DATA_WIDTH+1 bits:
  - ReLU and x<0: result forced to 0, sat=0.
  - Leaky ReLU and x<0: x = x >>> LEAKY_SHIFT (arithmetic) before rounding.
  - Half-away rounding: add 2^(SHIFT-1) if x>=0, else 2^(SHIFT-1)-1; then >>> SHIFT.
  - Truncate: >>> SHIFT only.
  - The extra bit guarantees no wrap at 0x7FFF_FFFF.
- Stage 2 (per lane):
  - Saturate to [-2^(Q-1), 2^(Q-1)-1].
  - out_sat[i]=1 iff clamping occurred.
- sat_count:
  - On each output transfer, add popcount(out_sat), holding at all-ones (no wrap).
  - sat_clr has priority: when sat_clr is asserted in the same cycle as a transfer, the result is 0 and that beat's flags are dropped.

Decomposition:
- Package relu_pkg holds:
  - act_mode_t enum (ACT_LINEAR, ACT_RELU, ACT_LEAKY)
  - rnd_mode_t enum (RND_HALF_AWAY, RND_TRUNC)
  - localparam helpers SAT_MAX/SAT_MIN as functions of Q
- One natural sub-module: relu_round_lane, combinational per-lane stage-1 and stage-2 math producing value and sat.
  - Instantiated LANES times in a generate loop.
  - The top level owns pipeline registers, handshake and counter.

Test Plan:
All scenarios use defaults, SHIFT=8, out_ready=1 unless stated.
- Rounding: lane0=0x0000_0180, linear, half-away -> 0x0002 after 2 cycles; with truncate -> 0x0001.
- Negative rounding: lane0=0xFFFF_FEC0 (-1.25 LSB), linear, half-away -> 0xFFFF; truncate -> 0xFFFE; sat=0.
- Activation: lane0=0x8000_0000, linear -> 0x8000 with sat=1; ReLU -> 0x0000 with sat=0; lane1=0xFFFF_F800, leaky -> 0xFFFF.
- Saturation/overflow: all lanes 0x7FFF_FFFF, half-away -> every lane 0x7FFF, out_sat=4'hF, sat_count 0->4; next cycle sat_clr=1 during another such beat -> sat_count=0.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,... -> no loss or duplication, in_ready drops while both stages are full, outputs stable while stalled, order preserved.
- Reset mid-stream: assert rst with v1=v2=1 -> next cycle out_valid=0, in_ready=1, sat_count=0; the next accepted beat emerges 2 cycles later, correct.
